// File: rtl/shared_dff_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_dff_pkg
// Description : Shared types, default parameters and the rotating first-set
//               helper used by the shared DFF-bank arbiter.
//               Contents:
//                 state_e       - FSM state encoding (IDLE, GRANT)
//                 DEF_*         - default parameter values
//                 pick_t        - {found, idx} result of a winner search
//                 rr_first_set  - first set request at or above ptr, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
package shared_dff_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;
  // Upper bound on requesters; sizes the helper function arguments.
  localparam int MAX_N_REQ     = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Returns the first set bit of req[n-1:0] starting at index ptr and
  // wrapping modulo n. Offsets are scanned from largest to smallest so the
  // smallest offset (closest to ptr) is the last one written and wins.
  function automatic pick_t rr_first_set(input logic [MAX_N_REQ-1:0] req,
                                         input logic [2:0]           ptr,
                                         input int                   n);
    pick_t      r;
    int         j;
    logic [2:0] j3;
    r = '0;
    for (int i = MAX_N_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) begin
          j = j - n;
        end
        j3 = 3'(j);
        if (req[j3]) begin
          r.found = 1'b1;
          r.idx   = j3;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_dff_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_dff_arbiter_if
// Description : Bus between the requesters and the shared DFF-bank arbiter.
//               Signals:
//                 req   [N_REQ]        level request per requester
//                 wdata [N_REQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//                 gnt   [N_REQ]        registered one-hot grant (or zero)
//                 q     [WIDTH]        shared register contents
//                 qn    [WIDTH]        complement of q
//                 busy                 arbiter is in the GRANT state
//               Modports: master (requester side), slave (arbiter side).
// Revision    : 1.0 - initial release
// ============================================================================
interface shared_dff_arbiter_if
  import shared_dff_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qn;
  logic                   busy;

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  q,
    input  qn,
    input  busy
  );

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output q,
    output qn,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/shared_dff_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner select for the shared DFF-bank arbiter.
//               Default build: round-robin, first set request at or above
//               ptr_i, wrapping. With SHARED_DFF_FIXED_PRIO_EN defined the
//               lowest set index wins and there is no ptr_i port.
//               Ports:
//                 req_i [N_REQ]   request vector
//                 ptr_i [PTR_W]   round-robin start index (default build)
//                 gnt_o [N_REQ]   one-hot winner, zero if no request
//                 any_o           at least one request set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import shared_dff_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = $clog2(DEF_N_REQ)
) (
  input  wire logic [N_REQ-1:0] req_i,
`ifndef SHARED_DFF_FIXED_PRIO_EN
  input  wire logic [PTR_W-1:0] ptr_i,
`endif
  output logic      [N_REQ-1:0] gnt_o,
  output logic                  any_o
);

  assign any_o = |req_i;

`ifdef SHARED_DFF_FIXED_PRIO_EN
  // Isolate the lowest set bit: x & -x.
  always_comb begin
    gnt_o = req_i & (~req_i + 1'b1);
  end
`else
  logic [MAX_N_REQ-1:0] w_req_ext;
  pick_t                w_pick;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = req_i;
    w_pick                 = rr_first_set(w_req_ext, 3'(ptr_i), N_REQ);
    gnt_o                  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_o[i] = w_pick.found && (w_pick.idx == 3'(i));
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/shared_dff_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_dff_arbiter
// Description : Arbiter and write sequencer for a shared WIDTH-bit DFF bank
//               (q/qn pair) written by N_REQ requesters. A winner is granted
//               for up to MAX_BURST back-to-back writes; dropping its request
//               ends the grant early. Every grant is followed by one IDLE
//               cycle with gnt=0.
//               Ports:
//                 clk   rising-edge clock
//                 rst   synchronous active-high reset
//                 bus   shared_dff_arbiter_if.slave (req, wdata in;
//                       gnt, q, qn, busy out)
//               Build option: SHARED_DFF_FIXED_PRIO_EN selects fixed lowest-
//               index priority and removes the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_dff_arbiter
  import shared_dff_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  wire logic            clk,
  input  wire logic            rst,
  shared_dff_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q,   gnt_d;
  logic [WIDTH-1:0]   q_q,     q_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  // Encoded index of the current grant holder.
  logic [PTR_W-1:0]   gidx_q,  gidx_d;
`ifndef SHARED_DFF_FIXED_PRIO_EN
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [PTR_W-1:0]   w_gidx_next;
`endif

  logic [N_REQ-1:0]   w_win_oh;
  logic               w_win_any;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_req_g;
  logic [WIDTH-1:0]   w_wdata_g;
  logic [CNT_W-1:0]   w_cnt_inc;

  // --------------------------------------------------------------------------
  // Winner select
  // --------------------------------------------------------------------------
  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (bus.req),
`ifndef SHARED_DFF_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (w_win_oh),
    .any_o (w_win_any)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_win_idx = PTR_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Granted requester's request and data
  // --------------------------------------------------------------------------
  assign w_req_g   = bus.req[gidx_q];
  assign w_wdata_g = bus.wdata[gidx_q*WIDTH +: WIDTH];
  assign w_cnt_inc = cnt_q + 1'b1;

`ifndef SHARED_DFF_FIXED_PRIO_EN
  // Pointer moves to the requester after the one just served, wrapping.
  assign w_gidx_next = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
`endif

  // --------------------------------------------------------------------------
  // FSM next state, burst counter and register bank
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    gidx_d  = gidx_q;
`ifndef SHARED_DFF_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (w_win_any) begin
          state_d = GRANT;
          gnt_d   = w_win_oh;
          gidx_d  = w_win_idx;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (w_req_g) begin
          q_d   = w_wdata_g;
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d = IDLE;
            gnt_d   = '0;
`ifndef SHARED_DFF_FIXED_PRIO_EN
            ptr_d   = w_gidx_next;
`endif
          end
        end else begin
          // Request dropped: release without writing.
          state_d = IDLE;
          gnt_d   = '0;
`ifndef SHARED_DFF_FIXED_PRIO_EN
          ptr_d   = w_gidx_next;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      gidx_q  <= '0;
`ifndef SHARED_DFF_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      gidx_q  <= gidx_d;
`ifndef SHARED_DFF_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.gnt  = gnt_q;
  assign bus.q    = q_q;
  assign bus.qn   = ~q_q;
  assign bus.busy = (state_q == GRANT);

endmodule
`default_nettype wire

// File: doc/shared_dff_arbiter.md
# shared_dff_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit bank of edge-triggered D flip-flops (q/qn pair), written by N_REQ requesters. Each requester raises a request, receives a one-hot grant, and writes its data word into the bank on every granted clock edge, up to a burst limit. The block sits between requester logic and the shared register and is the only writer of that register.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 8: register bank width.
- MAX_BURST, 4: maximum writes per grant (>=1).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  request per requester, level, held while writing.
- wdata  input  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant, or all zero.
- q  output  WIDTH  shared register contents.
- qn  output  WIDTH  always ~q.
- busy  output  1  high while in GRANT state.

## Operation
- One clock; reset is synchronous and active-high.
- Reset (rst high at an edge): q=0, qn=all ones, gnt=0, busy=0, state=IDLE, ptr=0, burst_cnt=0. Reset overrides any in-flight grant; no write occurs on that edge.
- States: IDLE, GRANT.
- IDLE: gnt=0. If any req bit is set, the winner is the first set index at or above ptr, wrapping modulo N_REQ. Next state is GRANT, gnt=onehot(winner), burst_cnt=0. If no request, stay in IDLE.
- GRANT, granted index g:
  - If req[g]=1: q<=wdata[g] and burst_cnt++. If the incremented count equals MAX_BURST: gnt<=0, ptr<=(g+1) mod N_REQ, go to IDLE. Otherwise stay in GRANT.
  - If req[g]=0: no write, gnt<=0, ptr<=(g+1) mod N_REQ, go to IDLE.
- Requests from non-granted indices are ignored during GRANT. They are evaluated at the next IDLE.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- q changes only on granted writes. wdata of non-granted requesters never reaches q.

## Timing
- req[i] sampled high in IDLE at edge k: gnt[i]=1 after edge k. First write at edge k+1, so q is valid after k+1.
- Each write takes one cycle. Up to MAX_BURST back-to-back writes per grant.
- Between consecutive grants there is always exactly one IDLE cycle with gnt=0. A lone continuous requester gets MAX_BURST writes every MAX_BURST+1 cycles.
- Dropping req[g] takes effect at the next edge: gnt falls after that edge, with no extra write.
- qn tracks q combinationally from the registered q, so it has no extra latency.
- Simultaneous requests in IDLE: one winner per the selection rule. Losers keep req high and win in later IDLE cycles.
- ptr wraps from N_REQ-1 to 0.

## Configuration
- SHARED_DFF_FIXED_PRIO_EN defined: the winner is the lowest set req index. ptr is not implemented, and the burst limit and IDLE gap still apply.
- Not defined: round-robin behaviour as described above.

## Structure
- Package shared_dff_pkg holds:
  - the state enum (IDLE, GRANT),
  - the default parameter constants,
  - a function computing the rotating first-set index.
- Sub-module rr_pick: combinational winner select taking req, ptr (and the fixed-priority variant), output one-hot. The FSM, burst counter and register bank stay in the top module.

## Test plan
- Reset check, then release with all req=0: q=0x00, qn=0xFF, gnt=0, busy=0, held for 10 cycles.
- req[2]=1 alone with wdata[2]=0x5A, held: gnt=4'b0100 one cycle after; q=0x5A after the next edge; gnt drops after exactly 4 writes; 1 IDLE cycle; regrant.
- req=4'b1111 held with distinct data 0x11/0x22/0x33/0x44: grants in order 0,1,2,3,0; each grant gives 4 writes; q ends each grant with that requester's word.
- Grant to index 1, req[1] dropped after 2 writes: gnt=0 next cycle, q keeps the second word, next winner is index 2 (ptr=2).
- rst asserted during the third write of a burst: after the edge q=0, gnt=0, state IDLE, ptr=0; no write of the data present at that edge.
- With SHARED_DFF_FIXED_PRIO_EN defined, req=4'b1010 held: index 1 wins every arbitration, and index 3 is never granted.
